// File: rtl/hack_pkg.sv
// hack_pkg: shared widths, instruction field positions and ALU control type for the Hack CPU
package hack_pkg;
    localparam int WORD_W    = 16;
    localparam int ADDR_W    = 15;
    localparam int CTYPE_BIT = 15;
    localparam int A_BIT     = 12;
    localparam int COMP_BASE = 6;
    localparam int DEST_A    = 5;
    localparam int DEST_D    = 4;
    localparam int DEST_M    = 3;
    localparam int JMP_LT    = 2;
    localparam int JMP_EQ    = 1;
    localparam int JMP_GT    = 0;

    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;
endpackage

// File: rtl/hack_alu.sv
// hack_alu: combinational Hack ALU with operand zero/negate, add/and select and output negate
module hack_alu
    import hack_pkg::*;
#(
    parameter int WIDTH = hack_pkg::WORD_W
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng
);
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] w_f;

    // zero then negate each operand, combine, then optionally negate the result
    always_comb begin
        w_x = zx ? '0 : x;
        w_x = nx ? ~w_x : w_x;
        w_y = zy ? '0 : y;
        w_y = ny ? ~w_y : w_y;
        w_f = f ? w_x + w_y : w_x & w_y;
        out = no ? ~w_f : w_f;
        zr  = (out == '0);
        ng  = out[WIDTH-1];
    end
endmodule

// File: rtl/hack_cpu.sv
// hack_cpu: Hack CPU core with A/D/PC registers, instruction decode and jump logic
module hack_cpu
    import hack_pkg::*;
#(
    parameter int WIDTH  = hack_pkg::WORD_W,
    parameter int ADDR_W = hack_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  instruction,
    input  logic [WIDTH-1:0]  inM,
    output logic [WIDTH-1:0]  outM,
    output logic              writeM,
    output logic [ADDR_W-1:0] addressM,
    output logic [ADDR_W-1:0] pc
);
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_d;
    logic [ADDR_W-1:0] r_pc;
    logic              w_c;
    logic              w_jump;
    logic              w_zr;
    logic              w_ng;
    logic [WIDTH-1:0]  w_y;
    logic [WIDTH-1:0]  w_alu;
    alu_ctrl_t         w_ctrl;

    assign w_c    = instruction[CTYPE_BIT];
    assign w_ctrl = alu_ctrl_t'(instruction[COMP_BASE +: 6]);
    assign w_y    = instruction[A_BIT] ? inM : r_a;

    hack_alu #(.WIDTH(WIDTH)) u_alu (
        .x  (r_d),
        .y  (w_y),
        .zx (w_ctrl.zx),
        .nx (w_ctrl.nx),
        .zy (w_ctrl.zy),
        .ny (w_ctrl.ny),
        .f  (w_ctrl.f),
        .no (w_ctrl.no),
        .out(w_alu),
        .zr (w_zr),
        .ng (w_ng)
    );

    assign w_jump = w_c & ((instruction[JMP_LT] & w_ng) |
                           (instruction[JMP_EQ] & w_zr) |
                           (instruction[JMP_GT] & ~w_ng & ~w_zr));

    assign outM     = w_alu;
    assign writeM   = w_c & instruction[DEST_M];
    assign addressM = r_a[ADDR_W-1:0];
    assign pc       = r_pc;

    // register writeback and PC sequencing; jump targets use A as it was before this edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a  <= '0;
            r_d  <= '0;
            r_pc <= '0;
        end else begin
            if (!w_c)
                r_a <= instruction;
            else if (instruction[DEST_A])
                r_a <= w_alu;
            if (w_c && instruction[DEST_D])
                r_d <= w_alu;
            r_pc <= w_jump ? r_a[ADDR_W-1:0] : r_pc + ADDR_W'(1);
        end
    end
endmodule

// File: tb/tb_hack_cpu.sv
// tb_hack_cpu: directed and random instruction streams checked against an arithmetic Hack model
module tb_hack_cpu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] instruction = 16'h0000;
    logic [15:0] inM = 16'h0000;
    logic [15:0] outM;
    logic        writeM;
    logic [14:0] addressM;
    logic [14:0] pc;

    int checks = 0;
    int failures = 0;

    logic [15:0] m_a = 16'h0000;
    logic [15:0] m_d = 16'h0000;
    logic [14:0] m_pc = 15'h0000;
    logic [15:0] e_out;
    logic        e_jump;
    logic [15:0] cur_ins;
    logic [14:0] old_pc;

    hack_cpu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instruction(instruction),
        .inM        (inM),
        .outM       (outM),
        .writeM     (writeM),
        .addressM   (addressM),
        .pc         (pc)
    );

    // free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_alu(input logic [5:0] c, input logic [15:0] x, input logic [15:0] y);
        int unsigned xv, yv, r;
        xv = c[5] ? 0 : int'(x);
        if (c[4]) xv = 65535 - xv;
        yv = c[3] ? 0 : int'(y);
        if (c[2]) yv = 65535 - yv;
        r = c[1] ? (xv + yv) % 65536 : (xv & yv);
        if (c[0]) r = 65535 - r;
        return r[15:0];
    endfunction

    function automatic logic taken(input logic [2:0] j, input logic [15:0] v);
        int sv;
        sv = (v >= 16'h8000) ? int'(v) - 65536 : int'(v);
        return (j[2] && sv < 0) || (j[1] && sv == 0) || (j[0] && sv > 0);
    endfunction

    task automatic apply(input logic [15:0] ins, input logic [15:0] im);
        instruction = ins;
        inM = im;
        cur_ins = ins;
        #2;
        e_out = ref_alu(ins[11:6], m_d, ins[12] ? im : m_a);
        e_jump = ins[15] && taken(ins[2:0], e_out);
        chk("outM", outM, e_out);
        chk("writeM", writeM, ins[15] & ins[3]);
        chk("addressM", addressM, m_a[14:0]);
        chk("pc", pc, m_pc);
    endtask

    task automatic clock();
        @(posedge clk);
        m_pc = e_jump ? m_a[14:0] : 15'((int'(m_pc) + 1) % 32768);
        if (!cur_ins[15]) m_a = cur_ins;
        else if (cur_ins[5]) m_a = e_out;
        if (cur_ins[15] && cur_ins[4]) m_d = e_out;
        #1;
    endtask

    task automatic exec(input logic [15:0] ins, input logic [15:0] im);
        apply(ins, im);
        clock();
    endtask

    initial begin
        #3;
        chk("rst_pc", pc, 0);
        chk("rst_addr", addressM, 0);
        #9 rst_n = 1'b1;

        for (int i = 0; i < 5; i++) exec(16'($urandom_range(0, 16'h7FFF)), 16'($urandom));
        chk("pc_at_5", pc, 5);
        instruction = 16'hE308;
        #1 rst_n = 1'b0;
        #1;
        chk("async_pc", pc, 0);
        chk("async_addr", addressM, 0);
        chk("async_d", outM, 0);
        rst_n = 1'b1;
        m_a = 0; m_d = 0; m_pc = 0;
        exec(16'h0000, 16'h0000);
        chk("pc_after_rst", pc, 1);

        exec(16'h0002, 0); exec(16'hEC10, 0); exec(16'h0003, 0);
        exec(16'hE090, 0); exec(16'h0000, 0);
        apply(16'hE308, 16'hBEEF);
        chk("store_out", outM, 16'h0005);
        chk("store_wr", writeM, 1);
        chk("store_addr", addressM, 0);
        clock();

        exec(16'hEA90, 0); exec(16'h000A, 0);
        exec(16'hE302, 0);
        chk("jeq_taken", pc, 16'h000A);
        exec(16'hEFD0, 0); exec(16'h000A, 0);
        old_pc = pc;
        exec(16'hE302, 0);
        chk("jeq_not", pc, old_pc + 15'd1);
        exec(16'hEA90, 0);
        old_pc = pc;
        exec(16'hE305, 0);
        chk("jne_not", pc, old_pc + 15'd1);

        exec(16'h0010, 0);
        exec(16'hFC10, 16'h1234);
        apply(16'hE308, 0);
        chk("mread_out", outM, 16'h1234);
        chk("mread_addr", addressM, 16'h0010);
        clock();

        exec(16'h0007, 0); exec(16'hEC10, 0); exec(16'h0014, 0);
        exec(16'hE327, 0);
        chk("dA_jmp_pc", pc, 16'h0014);
        chk("dA_jmp_addr", addressM, 16'h0007);

        exec(16'h7FFD, 0); exec(16'hEA87, 0);
        while (pc != 15'h7FFF && checks < 1000) exec(16'($urandom_range(0, 16'h7FFF)), 0);
        chk("pc_max", pc, 16'h7FFF);
        exec(16'h1234, 0);
        chk("pc_wrap", pc, 0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) exec(16'($urandom_range(0, 16'h7FFF)), 16'($urandom));
            else exec(16'h8000 | 16'($urandom), 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
